// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake segment store.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    COMMIT,
    DEAD
  } state_t;

  localparam logic [3:0] GRID_MAX = 4'd15;
  localparam int         LEN_W    = 6;

  // One cell in the given direction, plain 4-bit arithmetic.
  function automatic coord_t step_coord(coord_t c, dir_t d);
    coord_t n;
    n = c;
    case (d)
      UP:      n.y = c.y - 4'd1;
      RIGHT:   n.x = c.x + 4'd1;
      DOWN:    n.y = c.y + 4'd1;
      default: n.x = c.x - 4'd1;
    endcase
    return n;
  endfunction

  // UP/DOWN and RIGHT/LEFT differ only in bit 1 of the encoding.
  function automatic logic is_opposite(dir_t a, dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

  function automatic logic on_border(coord_t c);
    return (c.x == 4'd0) || (c.x == GRID_MAX) || (c.y == 4'd0) || (c.y == GRID_MAX);
  endfunction

endpackage

// File: rtl/segment_matcher.sv
// Compares one coordinate against every segment; only the first `count`
// entries can report a hit, the rest of the array is stale history.
module segment_matcher
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 50
) (
  input  coord_t                   target,
  input  coord_t [MAX_LEN-1:0]     segs,
  input  logic   [LEN_W-1:0]       count,
  output logic   [MAX_LEN-1:0]     hit
);

  // Per-segment equality, masked by the live segment count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hit = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      hit[i] = (segs[i] == target) && (LEN_W'(i) < count);
    end
  end

endmodule

// File: rtl/snake_store.sv
// Snake segment list, direction, length and game-over flag for a 16x16 grid.
// Answers per-pixel queries combinationally and advances one cell per tick
// through an IDLE -> CHECK -> COMMIT/DEAD sequence.
module snake_store
  import snake_pkg::*;
#(
  parameter int         MAX_LEN  = 50,
  parameter int         INIT_LEN = 2,
  parameter logic [3:0] INIT_X   = 4'd7,
  parameter logic [3:0] INIT_Y   = 4'd7
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       restart,
  input  logic       move_en,
  input  logic [1:0] dir,
  input  logic       grow,
  input  logic [3:0] apple_x,
  input  logic [3:0] apple_y,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       snakeHead,
  output logic       snakeBody,
  output logic       apple,
  output logic       border,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [5:0] length,
  output logic       GameOver,
  output logic       move_done
);

  coord_t [MAX_LEN-1:0] seg;
  coord_t [MAX_LEN-1:0] init_seg;
  logic   [LEN_W-1:0]   len_q;
  state_t               state;
  dir_t                 cur_dir;
  dir_t                 lat_dir;
  logic                 lat_grow;
  coord_t               nh_q;

  coord_t               query;
  coord_t               nh;
  dir_t                 eff_dir;
  logic   [LEN_W-1:0]   col_count;
  logic   [MAX_LEN-1:0] query_hit;
  logic   [MAX_LEN-1:0] col_hit;
  logic                 collision;

  // Start-of-game body: a horizontal line trailing left from the head;
  // entries past INIT_LEN repeat the tail so later growth stays consistent.
  always_comb begin
    init_seg = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < INIT_LEN) init_seg[i] = coord_t'{x: INIT_X - 4'(i), y: INIT_Y};
      else              init_seg[i] = coord_t'{x: INIT_X - 4'(INIT_LEN - 1), y: INIT_Y};
    end
  end

  assign query = coord_t'{x: x, y: y};

  // A reversal request keeps the current heading.
  assign eff_dir = is_opposite(lat_dir, cur_dir) ? cur_dir : lat_dir;
  assign nh      = step_coord(seg[0], eff_dir);

  // The tail only counts as an obstacle when it will not move away.
  assign col_count = lat_grow ? len_q : len_q - LEN_W'(1);

  segment_matcher #(.MAX_LEN(MAX_LEN)) u_query_match (
    .target (query),
    .segs   (seg),
    .count  (len_q),
    .hit    (query_hit)
  );

  segment_matcher #(.MAX_LEN(MAX_LEN)) u_collide_match (
    .target (nh),
    .segs   (seg),
    .count  (col_count),
    .hit    (col_hit)
  );

  // Index 0 is the head itself, so it never counts as body or obstacle.
  assign collision = on_border(nh) || (|(col_hit & ~MAX_LEN'(1)));

  assign snakeHead = (query == seg[0]);
  assign snakeBody = |(query_hit & ~MAX_LEN'(1));
  assign apple     = (x == apple_x) && (y == apple_y);
  assign border    = on_border(query);

  assign head_x = seg[0].x;
  assign head_y = seg[0].y;
  assign length = len_q;

  // Tick sequencer: latch request, check the next head, then shift the body.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: the segment array is reset like any other register; the query logic reads it from cycle 0.
      seg       <= init_seg;
      len_q     <= LEN_W'(INIT_LEN);
      state     <= IDLE;
      cur_dir   <= RIGHT;
      lat_dir   <= RIGHT;
      lat_grow  <= 1'b0;
      nh_q      <= '0;
      GameOver  <= 1'b0;
      move_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
      move_done <= 1'b0;
      if (restart) begin
        seg      <= init_seg;
        len_q    <= LEN_W'(INIT_LEN);
        state    <= IDLE;
        cur_dir  <= RIGHT;
        lat_dir  <= RIGHT;
        lat_grow <= 1'b0;
        GameOver <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (move_en) begin
              lat_dir  <= dir_t'(dir);
              lat_grow <= grow;
              state    <= CHECK;
            end
          end
          CHECK: begin
            cur_dir <= eff_dir;
            nh_q    <= nh;
            if (collision) begin
              GameOver <= 1'b1;
              state    <= DEAD;
            end else begin
              state <= COMMIT;
            end
          end
          COMMIT: begin
            seg <= {seg[MAX_LEN-2:0], nh_q};
            if (lat_grow && (len_q < LEN_W'(MAX_LEN))) len_q <= len_q + LEN_W'(1);
            move_done <= 1'b1;
            state     <= IDLE;
          end
          DEAD: begin
            state <= DEAD;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_store.sv
// Self-checking bench for snake_store against a queue-based snake model.
module tb_snake_store;

  localparam int MAXL = 50;
  localparam int D_UP = 0, D_RIGHT = 1, D_DOWN = 2, D_LEFT = 3;

  logic       clk = 1'b0;
  logic       nrst, restart, move_en, grow;
  logic [1:0] dir;
  logic [3:0] apple_x, apple_y, x, y;
  logic       snakeHead, snakeBody, apple, border;
  logic [3:0] head_x, head_y;
  logic [5:0] length;
  logic       GameOver, move_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
  } pt_t;

  pt_t body[$];
  int  m_dir;
  bit  m_dead;

  snake_store dut (
    .clk       (clk),
    .nrst      (nrst),
    .restart   (restart),
    .move_en   (move_en),
    .dir       (dir),
    .grow      (grow),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .x         (x),
    .y         (y),
    .snakeHead (snakeHead),
    .snakeBody (snakeBody),
    .apple     (apple),
    .border    (border),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .GameOver  (GameOver),
    .move_done (move_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    pt_t p;
    body.delete();
    for (int i = 0; i < 2; i++) begin
      p.x = 7 - i;
      p.y = 7;
      body.push_back(p);
    end
    m_dir  = D_RIGHT;
    m_dead = 1'b0;
  endfunction

  // Compare every query flag at one grid point against the model.
  task automatic probe_point(input int qx, input int qy);
    bit eh, eb, ea, ebd;
    x = 4'(qx);
    y = 4'(qy);
    #1;
    eh = (qx == body[0].x) && (qy == body[0].y);
    eb = 1'b0;
    for (int i = 1; i < body.size(); i++)
      if (body[i].x == qx && body[i].y == qy) eb = 1'b1;
    ea  = (qx == int'(apple_x)) && (qy == int'(apple_y));
    ebd = (qx == 0) || (qx == 15) || (qy == 0) || (qy == 15);
    checks += 4;
    if (snakeHead !== eh) begin
      errors++;
      $display("FAIL snakeHead at (%0d,%0d): got %b expected %b", qx, qy, snakeHead, eh);
    end
    if (snakeBody !== eb) begin
      errors++;
      $display("FAIL snakeBody at (%0d,%0d): got %b expected %b", qx, qy, snakeBody, eb);
    end
    if (apple !== ea) begin
      errors++;
      $display("FAIL apple at (%0d,%0d): got %b expected %b", qx, qy, apple, ea);
    end
    if (border !== ebd) begin
      errors++;
      $display("FAIL border at (%0d,%0d): got %b expected %b", qx, qy, border, ebd);
    end
  endtask

  task automatic probe_random(input int n);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      apple_x = 4'($urandom_range(0, 15));
      apple_y = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) probe_point(int'(apple_x), int'(apple_y));
      else                           probe_point($urandom_range(0, 15), $urandom_range(0, 15));
    end
  endtask

  // Drive one game tick and check pulse timing, game-over and the new head/length.
  task automatic do_move(input int d, input bit g);
    int  nd;
    pt_t nh;
    bit  coll, exp_commit;
    coll = 1'b0;
    nd   = m_dir;
    nh   = body[0];
    if (!m_dead) begin
      nd = (d == (m_dir ^ 2)) ? m_dir : d;
      case (nd)
        D_UP:    nh.y = body[0].y - 1;
        D_RIGHT: nh.x = body[0].x + 1;
        D_DOWN:  nh.y = body[0].y + 1;
        default: nh.x = body[0].x - 1;
      endcase
      if (nh.x == 0 || nh.x == 15 || nh.y == 0 || nh.y == 15) coll = 1'b1;
      for (int i = 1; i < body.size(); i++)
        if ((i <= body.size() - 2 || g) && body[i].x == nh.x && body[i].y == nh.y) coll = 1'b1;
    end
    exp_commit = !m_dead && !coll;

    @(negedge clk);
    dir     = 2'(d);
    grow    = g;
    move_en = 1'b1;
    @(negedge clk);  // request accepted; DUT now checking
    move_en = 1'($urandom_range(0, 1));
    dir     = 2'($urandom_range(0, 3));
    grow    = 1'($urandom_range(0, 1));
    checks++;
    if (move_done !== 1'b0) begin
      errors++;
      $display("FAIL move_done_early1: got %b expected 0", move_done);
    end
    @(negedge clk);  // check edge done
    checks += 2;
    if (move_done !== 1'b0) begin
      errors++;
      $display("FAIL move_done_early2: got %b expected 0", move_done);
    end
    if (GameOver !== (m_dead || coll)) begin
      errors++;
      $display("FAIL gameover_at_check: got %b expected %b", GameOver, m_dead || coll);
    end
    if (!m_dead) begin
      m_dir = nd;
      if (coll) m_dead = 1'b1;
      else begin
        body.push_front(nh);
        if (!(g && body.size() <= MAXL)) void'(body.pop_back());
      end
    end
    move_en = 1'b0;
    @(negedge clk);  // commit edge done
    checks += 5;
    if (move_done !== exp_commit) begin
      errors++;
      $display("FAIL move_done_pulse: got %b expected %b", move_done, exp_commit);
    end
    if (head_x !== 4'(body[0].x) || head_y !== 4'(body[0].y)) begin
      errors++;
      $display("FAIL head: got (%0d,%0d) expected (%0d,%0d)", head_x, head_y, body[0].x, body[0].y);
    end
    if (length !== 6'(body.size())) begin
      errors++;
      $display("FAIL length: got %0d expected %0d", length, body.size());
    end
    if (GameOver !== m_dead) begin
      errors++;
      $display("FAIL gameover: got %b expected %b", GameOver, m_dead);
    end
    @(negedge clk);
    if (move_done !== 1'b0) begin
      errors++;
      $display("FAIL move_done_width: got %b expected 0", move_done);
    end
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
    checks += 4;
    if (head_x !== 4'd7 || head_y !== 4'd7) begin
      errors++;
      $display("FAIL restart_head: got (%0d,%0d) expected (7,7)", head_x, head_y);
    end
    if (length !== 6'd2) begin
      errors++;
      $display("FAIL restart_length: got %0d expected 2", length);
    end
    if (GameOver !== 1'b0) begin
      errors++;
      $display("FAIL restart_gameover: got %b expected 0", GameOver);
    end
    if (move_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_move_done: got %b expected 0", move_done);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; restart = 1'b0; move_en = 1'b0; grow = 1'b0; dir = 2'd0;
    apple_x = 4'd3; apple_y = 4'd3; x = 4'd0; y = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (length !== 6'd2) begin
      errors++;
      $display("FAIL reset_length: got %0d expected 2", length);
    end
    if (GameOver !== 1'b0) begin
      errors++;
      $display("FAIL reset_gameover: got %b expected 0", GameOver);
    end
    if (move_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_move_done: got %b expected 0", move_done);
    end
    probe_point(7, 7);
    probe_point(6, 7);
    probe_point(3, 3);
    probe_point(0, 9);
  endtask

  task automatic test_move_right();
    do_move(D_RIGHT, 1'b0);
    @(negedge clk);
    probe_point(8, 7);
    probe_point(7, 7);
    probe_point(6, 7);
  endtask

  task automatic test_reversal();
    do_restart();
    do_move(D_LEFT, 1'b0);   // reversal: keeps moving right
    do_move(D_UP, 1'b1);
    @(negedge clk);
    probe_point(8, 6);
    probe_point(8, 7);
    probe_point(7, 7);
  endtask

  task automatic test_border();
    do_restart();
    repeat (7) do_move(D_RIGHT, 1'b0);
    do_move(D_RIGHT, 1'b0);  // head at x=14 steps onto the border
    do_move(D_UP, 1'b0);     // ignored while dead
    do_restart();
    @(negedge clk);
    probe_point(7, 7);
    probe_point(6, 7);
  endtask

  task automatic test_self_collision();
    do_restart();
    repeat (3) do_move(D_RIGHT, 1'b1);
    do_move(D_UP, 1'b0);
    do_move(D_LEFT, 1'b0);
    do_move(D_DOWN, 1'b0);   // re-enters a body segment
    // Chase the tail around a 2x2 loop: survives without grow.
    do_restart();
    repeat (2) do_move(D_RIGHT, 1'b1);
    do_move(D_UP, 1'b0);
    do_move(D_LEFT, 1'b0);
    do_move(D_DOWN, 1'b0);
    do_move(D_RIGHT, 1'b0);
    // Same approach with grow: the tail stays put and kills the head.
    do_restart();
    repeat (2) do_move(D_RIGHT, 1'b1);
    do_move(D_UP, 1'b0);
    do_move(D_LEFT, 1'b0);
    do_move(D_DOWN, 1'b1);
  endtask

  // restart while the request sits in CHECK (skip=1) or COMMIT (skip=2).
  task automatic test_restart_mid(input int skip);
    do_restart();
    @(negedge clk);
    dir     = 2'(D_UP);
    grow    = 1'b1;
    move_en = 1'b1;
    for (int k = 0; k < skip; k++) begin
      @(negedge clk);
      move_en = 1'b0;
    end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (move_done !== 1'b0) begin
        errors++;
        $display("FAIL mid_restart_move_done: got %b expected 0", move_done);
      end
      if (head_x !== 4'd7 || head_y !== 4'd7) begin
        errors++;
        $display("FAIL mid_restart_head: got (%0d,%0d) expected (7,7)", head_x, head_y);
      end
      if (length !== 6'd2) begin
        errors++;
        $display("FAIL mid_restart_length: got %0d expected 2", length);
      end
      @(negedge clk);
    end
    do_move(D_LEFT, 1'b0);   // heading must be back to RIGHT
  endtask

  task automatic test_max_len();
    int runs[7][2] = '{'{D_RIGHT, 6}, '{D_UP, 5}, '{D_LEFT, 11}, '{D_DOWN, 10},
                       '{D_RIGHT, 10}, '{D_UP, 4}, '{D_LEFT, 2}};
    do_restart();
    for (int r = 0; r < 7; r++)
      for (int k = 0; k < runs[r][1]; k++) do_move(runs[r][0], 1'b1);
    do_move(D_LEFT, 1'b1);   // already full: plain move
    do_move(D_LEFT, 1'b1);
    probe_random(12);
  endtask

  task automatic test_random();
    for (int game = 0; game < 4; game++) begin
      do_restart();
      for (int m = 0; m < 80; m++) begin
        do_move($urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        probe_random(3);
        if (m_dead) break;
      end
      do_move($urandom_range(0, 3), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_reversal();
    test_border();
    test_self_collision();
    test_restart_mid(1);
    test_restart_mid(2);
    test_max_len();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
